mem_stage_ws: RTL and testbench
===============================

MEM_STAGE_WS -- requirements
Module: mem_stage_ws

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, 32, width of the ALU address input.
REQ-003 Parameter MEM_DEPTH, 64, number of data words; power of two.
REQ-004 Parameter BASE_ADDR, 1024, byte address mapped to word 0.
REQ-005 Parameter WAIT_CYCLES, 4, memory access latency in cycles; legal range 1..15.
REQ-006 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-007 Port rst  input  1  reset, asynchronous, active-low.
REQ-008 Port mem_r_en  input  1  load request from EX/MEM.
REQ-009 Port mem_w_en  input  1  store request from EX/MEM.
REQ-010 Port alu_result  input  ADDR_W  byte address of the access.
REQ-011 Port st_val  input  DATA_W  store data.
REQ-012 Port mem_read_value  output  DATA_W  load data, registered.
REQ-013 Port freeze  output  1  pipeline stall request, combinational.
REQ-014 Port misalign  output  1  misaligned-access flag (see Configuration).

Function
REQ-015 Word index SHALL be ((alu_result - BASE_ADDR) >> log2(DATA_W/8)) modulo MEM_DEPTH; out-of-range addresses wrap with no error.
REQ-016 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-017 IDLE with mem_r_en or mem_w_en high SHALL latch the index, st_val and op type, load the counter with WAIT_CYCLES-1, and move to ACCESS.
REQ-018 ACCESS SHALL decrement the counter each edge; when the counter is 0, the edge SHALL perform the array read or write and move to DONE.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 freeze SHALL equal (mem_r_en | mem_w_en) & (state != DONE); a request is therefore frozen for exactly WAIT_CYCLES+1 cycles and released in DONE.
REQ-021 mem_read_value SHALL update only on a completed read and hold its value otherwise; on writes it is unchanged.
REQ-022 mem_r_en and mem_w_en both high SHALL be executed as a write only; mem_read_value is unchanged.
REQ-023 Request inputs changing while in ACCESS SHALL be ignored; latched values are used.
REQ-024 A request present in the cycle after DONE SHALL start a new access from IDLE; there is no bubble beyond that.

Reset
REQ-025 rst low SHALL force state IDLE, counter 0, mem_read_value 0 and misalign 0 immediately.
REQ-026 Reset during ACCESS SHALL abort the access; a pending write SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 With MEM_ALIGN_CHECK_EN defined, an access with alu_result low address bits nonzero SHALL complete with normal timing, assert misalign for the DONE cycle only, and suppress the write (a read returns the aligned word).
REQ-029 Without MEM_ALIGN_CHECK_EN, low address bits SHALL be ignored and misalign SHALL be tied to 0.

Structure
REQ-030 Package mem_stage_pkg SHALL hold the FSM state enum and the default BASE_ADDR and WAIT_CYCLES constants.
REQ-031 The storage array SHALL be a sub-module mem_ws_ram with a synchronous write and a synchronous read port, parametrised by DATA_W and MEM_DEPTH.

Verification
REQ-032 Store 0xDEADBEEF at 1024, then load 1024 with WAIT_CYCLES=4 -> freeze high 5 cycles per access; mem_read_value=0xDEADBEEF in the load's DONE cycle.
REQ-033 Store 0x11 at 1024+4*MEM_DEPTH, then load 1024 -> reads 0x11 (wrap).
REQ-034 Assert r and w together at 1028 with st_val=0x55 -> word 1 = 0x55; mem_read_value unchanged.
REQ-035 Pull rst low in the 2nd ACCESS cycle of a store 0x77 to 1032 -> state IDLE, freeze follows the request, later load of 1032 returns the prior value.
REQ-036 With MEM_ALIGN_CHECK_EN, store 0x99 to 1026 -> misalign=1 in DONE only; word 0 unchanged. Without the macro -> word 0 = 0x99, misalign=0.
REQ-037 Back-to-back loads with WAIT_CYCLES=1 -> freeze pattern 1,1,0,1,1,0 across the two loads; no extra bubble.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the wait-state memory stage.
//   state_t         : access FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   CNT_W           : width of the wait counter (latency 1..15 fits in 4 bits)
//   DEF_BASE_ADDR   : default byte address mapped to word 0
//   DEF_WAIT_CYCLES : default memory access latency in cycles
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 4;

endpackage

// File: rtl/mem_ws_ram.sv
// Data word storage for the memory stage: one synchronous write port and one
// synchronous read port. Contents are never reset; only the read data register
// is cleared by reset so the stage's load output starts at zero.
//   clk     : clock
//   rst     : asynchronous active-low reset (read register only)
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write word index
//   wr_data : write data
//   rd_en   : read strobe, rd_data loads array[rd_addr] on the rising edge
//   rd_addr : read word index
//   rd_data : registered read data, holds when rd_en is low
module mem_ws_ram #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_array [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_array[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_stage_ws.sv
// Pipeline memory stage with a fixed multi-cycle memory latency. A load or
// store seen in IDLE is latched, the stage waits WAIT_CYCLES cycles in ACCESS
// (array access on the last edge), then spends one cycle in DONE where the
// pipeline freeze is released. Store wins when load and store coincide.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag accesses whose low
// address bits are nonzero (flag valid in DONE only, store suppressed);
// without it the low bits are ignored and misalign is tied low.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   mem_r_en       : load request
//   mem_w_en       : store request
//   alu_result     : byte address
//   st_val         : store data
//   mem_read_value : registered load data, changes only on completed loads
//   freeze         : combinational stall request
//   misalign       : misaligned-access flag
module mem_stage_ws
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] st_val,
  output logic [DATA_W-1:0] mem_read_value,
  output logic              freeze,
  output logic              misalign
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE_VEC = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              op_w_reg;

  logic              req_any;
  logic [IDX_W-1:0]  req_idx;
  logic              start;
  logic              finish;
  logic              wr_block;
  logic              ram_we;
  logic              ram_re;

  assign req_any = mem_r_en | mem_w_en;
  // Truncating to IDX_W bits gives the modulo-MEM_DEPTH wrap for free.
  assign req_idx = IDX_W'((alu_result - BASE_VEC) >> OFF_W);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start      = 1'b0;
    finish     = 1'b0;
    freeze     = req_any & (state_reg != ST_DONE);
    case (state_reg)
      ST_IDLE: begin
        if (req_any) begin
          start      = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_reg == '0) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      op_w_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (start) begin
        idx_reg   <= req_idx;
        wdata_reg <= st_val;
        // Store takes priority over a simultaneous load.
        op_w_reg  <= mem_w_en;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_lat_reg;
  logic misalign_reg;
  logic req_mis;

  assign req_mis = |(alu_result & ADDR_W'(DATA_W / 8 - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_lat_reg  <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      if (start) begin
        mis_lat_reg <= req_mis;
      end
      // Set on the completing edge, so it is high only while in DONE.
      misalign_reg <= finish & mis_lat_reg;
    end
  end

  assign misalign = misalign_reg;
  assign wr_block = mis_lat_reg;
`else
  assign misalign = 1'b0;
  assign wr_block = 1'b0;
`endif

  // Strobes are derived from the state register, so an asynchronous reset
  // during ACCESS kills a pending store before the edge can commit it.
  assign ram_we = finish & op_w_reg & ~wr_block;
  assign ram_re = finish & ~op_w_reg;

  mem_ws_ram #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (idx_reg),
    .wr_data (wdata_reg),
    .rd_en   (ram_re),
    .rd_addr (idx_reg),
    .rd_data (mem_read_value)
  );

endmodule

// File: tb/tb_mem_stage_ws.sv
module tb_mem_stage_ws;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_val;
  logic [31:0] mem_read_value;
  logic        freeze, misalign;

  logic        r1, w1;
  logic [31:0] a1, d1;
  logic [31:0] rv1;
  logic        fz1, mis1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_ws #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_result(alu_result), .st_val(st_val),
    .mem_read_value(mem_read_value), .freeze(freeze), .misalign(misalign)
  );

  mem_stage_ws #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(w1),
    .alu_result(a1), .st_val(d1),
    .mem_read_value(rv1), .freeze(fz1), .misalign(mis1)
  );

  // ---------------- reference model ----------------
  logic [31:0] model_mem [64];
  logic [31:0] model_rv;

  function automatic int unsigned model_idx(input logic [31:0] a);
    int unsigned diff;
    diff = a - 32'd1024;
    return (diff / 4) % 64;
  endfunction

  function automatic bit model_mis(input logic [31:0] a);
    return ALIGN_EN && ((a % 4) != 0);
  endfunction

  task automatic model_update(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (w) begin
      if (!model_mis(a)) model_mem[model_idx(a)] = d;
    end else if (r) begin
      model_rv = model_mem[model_idx(a)];
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts in IDLE at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rv, input logic exp_mis, input string name);
    int frz;
    logic mis_early;
    frz = 0;
    mis_early = 1'b0;
    mem_r_en = r; mem_w_en = w; alu_result = a; st_val = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!freeze) break;
      frz++;
      if (misalign) mis_early = 1'b1;
      @(posedge clk); #1;
    end
    $display("txn %s r=%0b w=%0b addr=%0d data=%h frz=%0d rv=%h mis=%0b",
             name, r, w, a, d, frz, mem_read_value, misalign);
    chk({name, ".freeze_cycles"}, frz, 32'd5);
    chk({name, ".mis_during_access"}, {31'd0, mis_early}, 32'd0);
    chk({name, ".read_value"}, mem_read_value, exp_rv);
    chk({name, ".misalign_done"}, {31'd0, misalign}, {31'd0, exp_mis});
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic model_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                              input string name);
    logic [31:0] exp_rv;
    exp_rv = (r && !w) ? model_mem[model_idx(a)] : model_rv;
    do_access(r, w, a, d, exp_rv, model_mis(a), name);
    model_update(r, w, a, d);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rv;
    logic        exp_mis;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    mem_r_en = 0; mem_w_en = 0; alu_result = 0; st_val = 0;
    r1 = 0; w1 = 0; a1 = 0; d1 = 0;
    model_rv = 32'd0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;

    tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'd1280, 32'h11,       32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h11,       1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'd1028, 32'h55,       32'h11,       1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h55,       1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'd1026, 32'h99,       32'h55,       ALIGN_EN};
    tbl[7] = '{1'b1, 1'b0, 32'd1024, 32'h0,        ALIGN_EN ? 32'h11 : 32'h99, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 32'd1032, 32'h22,       ALIGN_EN ? 32'h11 : 32'h99, 1'b0};

    // Reset state
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset.read_value", mem_read_value, 32'd0);
    chk("reset.freeze", {31'd0, freeze}, 32'd0);
    chk("reset.misalign", {31'd0, misalign}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_access(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].exp_rv, tbl[i].exp_mis,
                $sformatf("tbl%0d", i));
      model_update(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].data);
    end

    // Reset in the 2nd ACCESS cycle of a store 0x77 to 1032
    mem_w_en = 1'b1; alu_result = 32'd1032; st_val = 32'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    $display("txn rst_abort freeze=%0b rv=%h mis=%0b", freeze, mem_read_value, misalign);
    chk("rst_abort.freeze_with_req", {31'd0, freeze}, 32'd1);
    chk("rst_abort.read_value", mem_read_value, 32'd0);
    chk("rst_abort.misalign", {31'd0, misalign}, 32'd0);
    mem_w_en = 1'b0;
    #1;
    chk("rst_abort.freeze_no_req", {31'd0, freeze}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    model_rv = 32'd0;
    model_access(1'b1, 1'b0, 32'd1032, 32'h0, "rst_abort.reload");

    // Fill every word, then random traffic against the model
    for (int i = 0; i < 64; i++)
      model_access(1'b0, 1'b1, 32'd1024 + 32'(4 * i), $urandom, $sformatf("fill%0d", i));
    for (int i = 0; i < 40; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = 32'd512 + 32'(4 * $urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      model_access(op != 1, op != 0, a, $urandom, $sformatf("rnd%0d", i));
    end

    // WAIT_CYCLES=1: store then two back-to-back loads, request held throughout
    w1 = 1'b1; a1 = 32'd1024; d1 = 32'hA5A5A5A5;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin w1 = 1'b0; r1 = 1'b1; end
      @(negedge clk);
      $display("txn b2b cyc=%0d freeze=%0b rv=%h", i, fz1, rv1);
      chk($sformatf("b2b.freeze%0d", i), {31'd0, fz1}, (i % 3 == 2) ? 32'd0 : 32'd1);
      if (i == 5 || i == 8) begin
        chk($sformatf("b2b.read_value%0d", i), rv1, 32'hA5A5A5A5);
        chk($sformatf("b2b.misalign%0d", i), {31'd0, mis1}, 32'd0);
      end
      @(posedge clk); #1;
    end
    r1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
